// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the 4-way cache controller
package cache_pkg;

  localparam int NUM_WAYS  = 4;
  localparam int PLRU_BITS = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REFILL,
    ST_FILL,
    ST_WTHRU,
    ST_DONE
  } state_e;

  localparam logic [2:0] MODE_WORD  = 3'b000;
  localparam logic [2:0] MODE_HALF  = 3'b001;
  localparam logic [2:0] MODE_BYTE  = 3'b010;
  localparam logic [2:0] MODE_UBYTE = 3'b011;
  localparam logic [2:0] MODE_UHALF = 3'b100;

  function automatic logic [NUM_WAYS-1:0] way_onehot(input logic [1:0] way);
    return 4'b0001 << way;
  endfunction

endpackage

// File: rtl/cache_plru.sv
// rtl/cache_plru.sv - per-set tree pseudo-LRU state and victim selection
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   index_i        set being looked at / updated
//   update_i       strobe: record an access to way_i in set index_i
//   way_i          accessed way
//   victim_o       way the tree currently points at for set index_i
//
// Tree bits: b0 chooses the half (0 => ways 0/1), b1 chooses within 0/1
// (0 => way 0), b2 chooses within 2/3 (0 => way 2).
module cache_plru
  import cache_pkg::*;
#(
  parameter int NoOfSets   = 16,
  parameter int indexWidth = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [indexWidth-1:0] index_i,
  input  logic                  update_i,
  input  logic [1:0]            way_i,
  output logic [1:0]            victim_o
);

  logic [PLRU_BITS-1:0] plru_q [NoOfSets];
  logic [PLRU_BITS-1:0] cur;

  assign cur = plru_q[index_i];

  always_comb begin
    victim_o = cur[0] ? {1'b1, cur[2]} : {1'b0, cur[1]};
  end

  // An access points the root at the other half and the leaf at the sibling.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < NoOfSets; s++) plru_q[s] <= '0;
    end else if (update_i) begin
      if (!way_i[1]) begin
        plru_q[index_i][0] <= 1'b1;
        plru_q[index_i][1] <= ~way_i[0];
      end else begin
        plru_q[index_i][0] <= 1'b0;
        plru_q[index_i][2] <= ~way_i[0];
      end
    end
  end

endmodule

// File: rtl/cache_way_ctrl.sv
// rtl/cache_way_ctrl.sv - tag/valid store, hit/miss and refill/write-through sequencing for a 4-way cache
//
// Optional feature macro: CACHE_PERF_CNT_EN (adds saturating hitCount/missCount outputs).
//
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   cpuReq/cpuWe/cpuAddr/cpuMode/cpuWData   CPU request, held until cpuReady
//   cpuReady, cpuHit                completion pulse and hit qualifier
//   wayWEn, wayIndex, wayTag, waySel, wayWData, wayMode   data-way control
//   memReq/memWe/memAddr/memWData   main-memory request, held until memAck
//   memRData, memAck                main-memory response
module cache_way_ctrl
  import cache_pkg::*;
#(
  parameter int tagSize    = 26,
  parameter int NoOfSets   = 16,
  parameter int indexWidth = 4,
  parameter int dataWidth  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpuReq,
  input  logic                  cpuWe,
  input  logic [31:0]           cpuAddr,
  input  logic [2:0]            cpuMode,
  input  logic [dataWidth-1:0]  cpuWData,
  output logic                  cpuReady,
  output logic                  cpuHit,
  output logic [NUM_WAYS-1:0]   wayWEn,
  output logic [indexWidth-1:0] wayIndex,
  output logic [tagSize-1:0]    wayTag,
  output logic [1:0]            waySel,
  output logic [dataWidth-1:0]  wayWData,
  output logic [2:0]            wayMode,
  output logic                  memReq,
  output logic                  memWe,
  output logic [31:0]           memAddr,
  output logic [dataWidth-1:0]  memWData,
  input  logic [dataWidth-1:0]  memRData,
  input  logic                  memAck
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]           hitCount,
  output logic [31:0]           missCount
`endif
);

  state_e                state_q;
  logic                  we_q;
  logic                  hit_q;
  logic [dataWidth-1:0]  wdata_q;
  logic [NUM_WAYS-1:0]   valid_q [NoOfSets];
  logic [tagSize-1:0]    tag_q   [NUM_WAYS][NoOfSets];

  logic                  hit;
  logic [1:0]            hit_way;
  logic [1:0]            victim;
  logic [1:0]            plru_victim;
  logic                  plru_upd;
  logic [1:0]            plru_way;
  logic                  fill_evt;

  // The byte offset only matters inside the ways; the controller works on words.
  logic unused_offset;
  assign unused_offset = ^cpuAddr[1:0];

  // wayTag/wayIndex double as the latched request address.
  always_comb begin
    hit     = 1'b0;
    hit_way = 2'd0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[wayIndex][w] && tag_q[w][wayIndex] == wayTag) begin
        hit     = 1'b1;
        hit_way = 2'(w);
      end
    end
  end

  // Lowest-numbered invalid way wins over the PLRU choice.
  always_comb begin
    victim = plru_victim;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[wayIndex][w]) victim = 2'(w);
    end
  end

  assign fill_evt = (state_q == ST_REFILL) && memAck;
  assign plru_upd = ((state_q == ST_LOOKUP) && hit) || fill_evt;
  assign plru_way = (state_q == ST_LOOKUP) ? hit_way : victim;

  cache_plru #(
    .NoOfSets  (NoOfSets),
    .indexWidth(indexWidth)
  ) u_plru (
    .clk_i   (clk),
    .rst_ni  (reset),
    .index_i (wayIndex),
    .update_i(plru_upd),
    .way_i   (plru_way),
    .victim_o(plru_victim)
  );

  // Tag array needs no reset: a tag is only trusted behind its valid bit.
  always_ff @(posedge clk) begin
    if (fill_evt) tag_q[victim][wayIndex] <= wayTag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      hit_q    <= 1'b0;
      wdata_q  <= '0;
      for (int s = 0; s < NoOfSets; s++) valid_q[s] <= '0;
      cpuReady <= 1'b0;
      cpuHit   <= 1'b0;
      wayWEn   <= '0;
      wayIndex <= '0;
      wayTag   <= '0;
      waySel   <= '0;
      wayWData <= '0;
      wayMode  <= '0;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWData <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cpuReq) begin
            wayTag   <= cpuAddr[31 -: tagSize];
            wayIndex <= cpuAddr[indexWidth+1:2];
            wayMode  <= cpuMode;
            we_q     <= cpuWe;
            wdata_q  <= cpuWData;
            state_q  <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          memAddr  <= {wayTag, wayIndex, 2'b00};
          memWData <= wdata_q;
          if (we_q) begin
            // Store: update the way only on a hit, always write through.
            memReq <= 1'b1;
            memWe  <= 1'b1;
            hit_q  <= hit;
            if (hit) begin
              wayWEn   <= way_onehot(hit_way);
              wayWData <= wdata_q;
              waySel   <= hit_way;
            end
            state_q <= ST_WTHRU;
          end else if (hit) begin
            waySel   <= hit_way;
            cpuReady <= 1'b1;
            cpuHit   <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            memReq  <= 1'b1;
            memWe   <= 1'b0;
            state_q <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (memAck) begin
            memReq   <= 1'b0;
            wayWEn   <= way_onehot(victim);
            wayWData <= memRData;
            waySel   <= victim;
            valid_q[wayIndex][victim] <= 1'b1;
            state_q  <= ST_FILL;
          end
        end
        ST_FILL: begin
          wayWEn   <= '0;
          cpuReady <= 1'b1;
          cpuHit   <= 1'b0;
          state_q  <= ST_DONE;
        end
        ST_WTHRU: begin
          wayWEn <= '0;
          if (memAck) begin
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            cpuReady <= 1'b1;
            cpuHit   <= hit_q;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          cpuReady <= 1'b0;
          cpuHit   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef CACHE_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hitCount  <= '0;
      missCount <= '0;
    end else if (state_q == ST_DONE) begin
      if (cpuHit) begin
        if (hitCount != 32'hFFFF_FFFF) hitCount <= hitCount + 32'd1;
      end else begin
        if (missCount != 32'hFFFF_FFFF) missCount <= missCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/cache_way_ctrl.md
Name: cache_way_ctrl

Overview:
Sequencing controller for the 4-way set-associative cache built from four cacheWay data arrays. It owns the tag/valid store and tree pseudo-LRU state per set, and resolves hit/miss. It drives the per-way write enables and index, and runs the main-memory refill/write-through handshake. It sits between the CPU load/store port and the four data ways plus the main-memory port.

Parameters:
tagSize, 26, tag bits per line (32 - indexWidth - 2 byte-offset bits)
NoOfSets, 16, sets per way
indexWidth, 4, log2(NoOfSets)
dataWidth, 32, word width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
cpuReq  in  1  request valid; held with all request fields until cpuReady
cpuWe  in  1  1=store, 0=load
cpuAddr  in  32  byte address: [31:32-tagSize]=tag, [indexWidth+1:2]=index, [1:0]=offset
cpuMode  in  3  000 word, 001 half, 010 byte, 011 ubyte, 100 uhalf; forwarded to ways
cpuReady  out  1  one-cycle pulse: request complete
cpuHit  out  1  qualifies cpuReady; 1 when served without refill
wayWEn  out  4  one-hot per-way write enable
wayIndex  out  indexWidth  set index to all ways
wayTag  out  tagSize  tag to all ways
waySel  out  2  way whose readData the datapath muxes out
wayWData  out  32  cpuData on store hit, memRData on refill
cpuWData  in  32  store data
memReq  out  1  main-memory request; held until memAck
memWe  out  1  1=write-through, 0=line read
memAddr  out  32  word-aligned address
memWData  out  32  write-through data
memRData  in  32  refill data, valid with memAck
memAck  in  1  one-cycle completion pulse from main memory

Behaviour:
- Reset (async, reset=0): FSM->IDLE; all valid bits 0; all PLRU bits 0; every output 0.
- States: IDLE, LOOKUP, REFILL, FILL, WTHRU, DONE.
- IDLE: cpuReq=1 -> latch addr/we/mode/wdata, go LOOKUP.
- LOOKUP (1 cycle): compare the latched tag against the 4 valid tags of the set.
  - Hit, load -> waySel=hit way; DONE with cpuHit=1. Total load-hit latency 2 cycles (cpuReq sampled -> cpuReady asserted 2 edges later).
  - Hit, store -> wayWEn one-hot on hit way for exactly 1 cycle; go WTHRU.
  - Miss, load -> REFILL.
  - Miss, store -> WTHRU; no write-allocate, no way write.
- REFILL: memReq=1, memWe=0, memAddr={addr[31:2],2'b00}; on memAck go FILL.
- FILL: victim = first invalid way (lowest number), else the PLRU way. wayWEn[victim]=1 for 1 cycle with memRData registered. Set valid, write tag, waySel=victim. DONE with cpuHit=0.
- WTHRU: memReq=1, memWe=1, memWData=cpuWData; on memAck go DONE; cpuHit is the LOOKUP result.
- DONE: cpuReady=1 for 1 cycle, then IDLE. A new cpuReq is accepted at the earliest in the following IDLE cycle (no back-to-back overlap).
- PLRU: 3 bits per set, tree (b0 root: 0=>ways0/1 side).
  - Updated on a load hit, a store hit and a fill, pointing away from the accessed way.
  - Victim is found by following the bits toward the pointed side.
- memAck outside REFILL/WTHRU is ignored. cpuReq changes mid-transaction are ignored, since fields are latched.
- Reset mid-transaction aborts immediately and drops memReq. Memory must tolerate the abandoned request.
- Index and tag slices come from parameters; the byte offset is always [1:0].

Optional Feature:
CACHE_PERF_CNT_EN
- Defined: adds 32-bit saturating hitCount and missCount output ports. One increment per DONE, selected by cpuHit. Both counters reset to 0 and saturate at 0xFFFFFFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cache_pkg: FSM state encoding, mode codes (MODE_WORD..MODE_UHALF), way count constant 4, PLRU width 3.
- Sub-module cache_plru: per-set PLRU bit array. Inputs are index, update strobe and accessed way; output is the victim way. Combinational victim, registered update, async active-low reset.

Test Plan:
- Reset, then load 0x0000_0040 with memRData=0xDEADBEEF on memAck -> memReq/memWe=0 at memAddr 0x40; wayWEn=0001; cpuReady with cpuHit=0.
- Repeat the same load -> cpuReady 2 cycles after cpuReq, cpuHit=1, waySel=0, memReq never asserted.
- Store 0x1234_5678 to 0x40 (hit) -> wayWEn=0001 for 1 cycle, then memReq/memWe=1 at 0x40 with memWData=0x12345678; cpuReady with cpuHit=1.
- Five loads with distinct tags to set 0, followed by a hit on way 0 -> first four fill ways 0,1,2,3. The fifth evicts the PLRU victim (way 2 given the access order), not way 0.
- Store miss to 0x80 -> no wayWEn; write-through only; a following load to 0x80 misses.
- Assert reset=0 during REFILL -> memReq drops the same cycle, all valid bits are cleared, and the next load of a previously cached address misses.
